// File: rtl/power_rail_sequencer_pkg.sv
// Shared definitions for the rail sequencer: state encodings and the index-width helper.
package power_rail_sequencer_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [STATE_W-1:0] ST_RAMP      = 3'd1;
  localparam logic [STATE_W-1:0] ST_SETTLE_UP = 3'd2;
  localparam logic [STATE_W-1:0] ST_UP        = 3'd3;
  localparam logic [STATE_W-1:0] ST_RAMP_DN   = 3'd4;
  localparam logic [STATE_W-1:0] ST_SETTLE_DN = 3'd5;
  localparam logic [STATE_W-1:0] ST_FAULT     = 3'd6;

  function automatic int clog2_int(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/power_rail_sequencer_pg_deglitch.sv
// Per-rail power-good conditioning: 2-flop synchroniser then a stability filter.
module pg_deglitch #(
  parameter int DEGLITCH = 4
) (
  input  logic sysclk,
  input  logic reset_INV,
  input  logic pg_raw,
  output logic pg_f
);

  localparam int CNT_W = (DEGLITCH > 1) ? $clog2(DEGLITCH) : 1;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             pg_f_q, pg_f_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the filtered value.
  always_comb begin
    sync1_d = pg_raw;
    sync2_d = sync1_q;
    pg_f_d  = pg_f_q;
    cnt_d   = '0;
    if (sync2_q != pg_f_q) begin
      if (cnt_q == CNT_W'(DEGLITCH - 1)) begin
        pg_f_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      pg_f_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      pg_f_q  <= pg_f_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pg_f = pg_f_q;

endmodule

// File: rtl/power_rail_sequencer.sv
// N-rail power sequencer: ordered ramp-up with pg/settle gating, reverse shutdown,
// continuous monitoring of enabled rails, latched fault with offending rail index.
module power_rail_sequencer
  import power_rail_sequencer_pkg::*;
#(
  parameter int NUM_RAILS     = 6,
  parameter int TIMER_WIDTH   = 16,
  parameter int PG_TIMEOUT    = 16000,
  parameter int SETTLE_CYCLES = 8000,
  parameter int DEGLITCH      = 4,
  localparam int IDX_W        = clog2_int(NUM_RAILS)
) (
  input  logic                 sysclk,
  input  logic                 reset_INV,
  input  logic                 enable,
  input  logic                 fault_clear,
  input  logic [NUM_RAILS-1:0] pg,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 all_good,
  output logic                 fault,
  output logic [IDX_W-1:0]     fault_rail,
  output logic [STATE_W-1:0]   state
);

  if ((longint'(PG_TIMEOUT) > (longint'(1) << TIMER_WIDTH) - 1) ||
      (longint'(SETTLE_CYCLES) > (longint'(1) << TIMER_WIDTH) - 1)) begin : g_timer_too_narrow
    $error("TIMER_WIDTH too small for PG_TIMEOUT/SETTLE_CYCLES");
  end

  logic [NUM_RAILS-1:0] pg_f;

  for (genvar i = 0; i < NUM_RAILS; i++) begin : g_pg
    pg_deglitch #(.DEGLITCH(DEGLITCH)) u_pg_deglitch (
      .sysclk    (sysclk),
      .reset_INV (reset_INV),
      .pg_raw    (pg[i]),
      .pg_f      (pg_f[i])
    );
  end

  logic [STATE_W-1:0]     state_q, state_d;
  logic [IDX_W-1:0]       k_q, k_d;
  logic [TIMER_WIDTH-1:0] timer_q, timer_d, timer_inc;
  logic [NUM_RAILS-1:0]   rail_en_q, rail_en_d;
  logic                   all_good_q, all_good_d;
  logic                   fault_q, fault_d;
  logic [IDX_W-1:0]       fault_rail_q, fault_rail_d;

  logic [NUM_RAILS-1:0]   mon_mask, mon_bad;
  logic [IDX_W-1:0]       mon_idx;
  logic                   mon_fault;

  // Rails below k are always watched; rail k joins once its pg has been seen.
  always_comb begin
    mon_mask = '0;
    for (int j = 0; j < NUM_RAILS; j++) begin
      if (state_q == ST_RAMP) begin
        mon_mask[j] = (IDX_W'(j) < k_q);
      end else if (state_q == ST_SETTLE_UP || state_q == ST_UP) begin
        mon_mask[j] = (IDX_W'(j) <= k_q);
      end
    end
    mon_bad   = mon_mask & ~pg_f;
    mon_fault = |mon_bad;
    mon_idx   = '0;
    for (int j = NUM_RAILS - 1; j >= 0; j--) begin
      if (mon_bad[j]) mon_idx = IDX_W'(j);
    end
  end

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    timer_d      = timer_inc;
    rail_en_d    = rail_en_q;
    fault_d      = fault_q;
    fault_rail_d = fault_rail_q;
    case (state_q)
      ST_IDLE: begin
        rail_en_d    = '0;
        fault_d      = 1'b0;
        fault_rail_d = '0;
        k_d          = '0;
        timer_d      = '0;
        if (enable) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        rail_en_d[k_q] = 1'b1;
        if (mon_fault) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = mon_idx;
        end else if (!enable) begin
          state_d = ST_RAMP_DN;
          timer_d = '0;
        end else if (pg_f[k_q]) begin
          state_d = ST_SETTLE_UP;
          timer_d = '0;
        end else if (timer_q == TIMER_WIDTH'(PG_TIMEOUT - 1)) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = k_q;
        end
      end
      ST_SETTLE_UP: begin
        if (mon_fault) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = mon_idx;
        end else if (!enable) begin
          state_d = ST_RAMP_DN;
          timer_d = '0;
        end else if (timer_q == TIMER_WIDTH'(SETTLE_CYCLES - 1)) begin
          timer_d = '0;
          if (k_q == IDX_W'(NUM_RAILS - 1)) begin
            state_d = ST_UP;
          end else begin
            k_d     = k_q + 1'b1;
            state_d = ST_RAMP;
          end
        end
      end
      ST_UP: begin
        if (mon_fault) begin
          state_d      = ST_FAULT;
          rail_en_d    = '0;
          fault_d      = 1'b1;
          fault_rail_d = mon_idx;
        end else if (!enable) begin
          state_d = ST_RAMP_DN;
          k_d     = IDX_W'(NUM_RAILS - 1);
          timer_d = '0;
        end
      end
      // A rail that never drops within the timeout is left behind; shutdown continues.
      ST_RAMP_DN: begin
        rail_en_d[k_q] = 1'b0;
        if (!pg_f[k_q] || timer_q == TIMER_WIDTH'(PG_TIMEOUT - 1)) begin
          state_d = ST_SETTLE_DN;
          timer_d = '0;
        end
      end
      ST_SETTLE_DN: begin
        if (timer_q == TIMER_WIDTH'(SETTLE_CYCLES - 1)) begin
          timer_d = '0;
          if (k_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            k_d     = k_q - 1'b1;
            state_d = ST_RAMP_DN;
          end
        end
      end
      ST_FAULT: begin
        rail_en_d = '0;
        if (fault_clear && !enable) begin
          state_d      = ST_IDLE;
          fault_d      = 1'b0;
          fault_rail_d = '0;
          k_d          = '0;
          timer_d      = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        rail_en_d = '0;
        timer_d   = '0;
      end
    endcase
    all_good_d = (state_d == ST_UP);
  end

  always_ff @(posedge sysclk or negedge reset_INV) begin
    if (!reset_INV) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      timer_q      <= '0;
      rail_en_q    <= '0;
      all_good_q   <= 1'b0;
      fault_q      <= 1'b0;
      fault_rail_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      timer_q      <= timer_d;
      rail_en_q    <= rail_en_d;
      all_good_q   <= all_good_d;
      fault_q      <= fault_d;
      fault_rail_q <= fault_rail_d;
    end
  end

  assign rail_en    = rail_en_q;
  assign all_good   = all_good_q;
  assign fault      = fault_q;
  assign fault_rail = fault_rail_q;
  assign state      = state_q;

endmodule

// File: tb/tb_power_rail_sequencer.sv
// Directed bench for power_rail_sequencer with a delayed-pg plant model and an expectation queue.
module tb_power_rail_sequencer;

  localparam int NR = 3;

  logic       clk = 1'b0;
  logic       reset_INV;
  logic       enable;
  logic       fault_clear;
  logic [2:0] pg;
  logic [2:0] rail_en;
  logic       all_good;
  logic       fault;
  logic [1:0] fault_rail;
  logic [2:0] state;

  logic [2:0] pg_kill;
  logic [2:0] en_d1 = '0, en_d2 = '0, en_d3 = '0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  power_rail_sequencer #(
    .NUM_RAILS    (NR),
    .TIMER_WIDTH  (16),
    .PG_TIMEOUT   (20),
    .SETTLE_CYCLES(5),
    .DEGLITCH     (2)
  ) dut (
    .sysclk      (clk),
    .reset_INV   (reset_INV),
    .enable      (enable),
    .fault_clear (fault_clear),
    .pg          (pg),
    .rail_en     (rail_en),
    .all_good    (all_good),
    .fault       (fault),
    .fault_rail  (fault_rail),
    .state       (state)
  );

  always #5 clk = ~clk;

  // Plant: each rail's pg follows its enable three cycles later unless forced low.
  always @(posedge clk) begin
    en_d1 <= rail_en;
    en_d2 <= en_d1;
    en_d3 <= en_d2;
  end
  assign pg = en_d3 & ~pg_kill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs, e.exp);
    end else begin
      chk("sb_underflow", obs, 32'hFFFF_FFFF);
    end
  endtask

  task automatic wait_en_change(input int budget);
    logic [2:0] start;
    int n;
    start = rail_en;
    n = 0;
    while (rail_en === start && n < budget) begin
      @(negedge clk);
      n++;
    end
    observe({29'd0, rail_en});
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget);
    int n;
    n = 0;
    while (state !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int cyc;
    reset_INV   = 1'b0;
    enable      = 1'b0;
    fault_clear = 1'b0;
    pg_kill     = 3'b000;
    repeat (3) @(negedge clk);

    expect_val("rst_rail_en", 0);
    expect_val("rst_state", 0);
    expect_val("rst_fault", 0);
    expect_val("rst_all_good", 0);
    expect_val("rst_fault_rail", 0);
    observe({29'd0, rail_en});
    observe({29'd0, state});
    observe({31'd0, fault});
    observe({31'd0, all_good});
    observe({30'd0, fault_rail});
    reset_INV = 1'b1;
    @(negedge clk);

    // Nominal power-up
    enable = 1'b1;
    expect_val("up_en0", 3'b001);
    expect_val("up_en1", 3'b011);
    expect_val("up_en2", 3'b111);
    wait_en_change(60);
    wait_en_change(60);
    wait_en_change(60);
    wait_state(3'd3, 60);
    expect_val("up_state", 3);
    expect_val("up_all_good", 1);
    expect_val("up_fault", 0);
    observe({29'd0, state});
    observe({31'd0, all_good});
    observe({31'd0, fault});

    // Single-cycle glitch on rail 0 must be filtered
    pg_kill[0] = 1'b1;
    @(negedge clk);
    pg_kill[0] = 1'b0;
    expect_val("glitch_state", 3);
    expect_val("glitch_fault", 0);
    repeat (12) @(negedge clk);
    observe({29'd0, state});
    observe({31'd0, fault});

    // Sustained drop on rail 0
    pg_kill[0] = 1'b1;
    repeat (4) @(negedge clk);
    pg_kill[0] = 1'b0;
    expect_val("drop_state", 6);
    expect_val("drop_fault", 1);
    expect_val("drop_fault_rail", 0);
    expect_val("drop_rail_en", 0);
    expect_val("drop_all_good", 0);
    wait_state(3'd6, 30);
    observe({29'd0, state});
    observe({31'd0, fault});
    observe({30'd0, fault_rail});
    observe({29'd0, rail_en});
    observe({31'd0, all_good});

    // fault_clear ignored while enable is high
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    expect_val("clr_ignored_state", 6);
    expect_val("clr_ignored_fault", 1);
    @(negedge clk);
    observe({29'd0, state});
    observe({31'd0, fault});

    enable      = 1'b0;
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    expect_val("clr_state", 0);
    expect_val("clr_fault", 0);
    expect_val("clr_fault_rail", 0);
    observe({29'd0, state});
    observe({31'd0, fault});
    observe({30'd0, fault_rail});
    repeat (10) @(negedge clk);

    // Fresh ramp from rail 0 after clearing
    enable = 1'b1;
    expect_val("re_en0", 3'b001);
    expect_val("re_en1", 3'b011);
    expect_val("re_en2", 3'b111);
    wait_en_change(60);
    wait_en_change(60);
    wait_en_change(60);
    wait_state(3'd3, 60);
    expect_val("re_state", 3);
    observe({29'd0, state});

    // Reverse shutdown
    enable = 1'b0;
    @(negedge clk);
    expect_val("dn_state_first", 4);
    expect_val("dn_all_good_first", 0);
    observe({29'd0, state});
    observe({31'd0, all_good});
    expect_val("dn_en2", 3'b011);
    expect_val("dn_en1", 3'b001);
    expect_val("dn_en0", 3'b000);
    wait_en_change(60);
    wait_en_change(60);
    wait_en_change(60);
    wait_state(3'd0, 60);
    expect_val("dn_state_idle", 0);
    expect_val("dn_all_good", 0);
    observe({29'd0, state});
    observe({31'd0, all_good});
    repeat (10) @(negedge clk);

    // Ramp timeout on rail 1
    pg_kill[1] = 1'b1;
    enable     = 1'b1;
    expect_val("to_en0", 3'b001);
    expect_val("to_en1", 3'b011);
    wait_en_change(60);
    wait_en_change(60);
    cyc = 0;
    while (state !== 3'd6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    // The timer starts on RAMP entry, one cycle before rail_en[1] rises.
    chk("to_latency_window", {31'd0, (cyc >= 19 && cyc <= 20)}, 1);
    expect_val("to_fault", 1);
    expect_val("to_fault_rail", 1);
    expect_val("to_rail_en", 0);
    observe({31'd0, fault});
    observe({30'd0, fault_rail});
    observe({29'd0, rail_en});
    enable      = 1'b0;
    fault_clear = 1'b1;
    @(negedge clk);
    fault_clear = 1'b0;
    pg_kill[1]  = 1'b0;
    expect_val("to_clr_state", 0);
    observe({29'd0, state});
    repeat (10) @(negedge clk);

    // Asynchronous reset while ramping rail 2
    enable = 1'b1;
    expect_val("ar_en0", 3'b001);
    expect_val("ar_en1", 3'b011);
    expect_val("ar_en2", 3'b111);
    wait_en_change(60);
    wait_en_change(60);
    wait_en_change(60);
    expect_val("ar_state_ramp", 1);
    observe({29'd0, state});
    #2;
    reset_INV = 1'b0;
    #1;
    expect_val("ar_rail_en", 0);
    expect_val("ar_state", 0);
    expect_val("ar_all_good", 0);
    observe({29'd0, rail_en});
    observe({29'd0, state});
    observe({31'd0, all_good});
    @(negedge clk);
    enable    = 1'b0;
    reset_INV = 1'b1;
    repeat (3) @(negedge clk);
    expect_val("ar_after_state", 0);
    observe({29'd0, state});

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
